// File: rtl/aes128_ctr_stream_pkg.sv
// Shared types and AES-128 round helpers for the CTR stream front end and its core.
package aes128_ctr_stream_pkg;

  localparam int AES_BLK_W  = 128;
  localparam int AES_WORDS  = 4;
  localparam int AES_ROUNDS = 10;

  typedef enum logic [1:0] {IDLE_S, KICK_S, FILL_S, EMIT_S} ctr_state_t;
  typedef enum logic {CORE_IDLE_S, CORE_BUSY_S} core_state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as x^254 (the field inverse, 0 maps to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x3, x7, x15, x31, x63, x127, inv;
    x3   = gf_mul(gf_mul(a, a), a);
    x7   = gf_mul(gf_mul(x3, x3), a);
    x15  = gf_mul(gf_mul(x7, x7), a);
    x31  = gf_mul(gf_mul(x15, x15), a);
    x63  = gf_mul(gf_mul(x31, x31), a);
    x127 = gf_mul(gf_mul(x63, x63), a);
    inv  = gf_mul(x127, x127);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Byte i of the state is bits [127-8i -: 8]; bytes are column-major.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[r+4*c] = b[r + 4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c];
      a1 = t[4*c+1];
      a2 = t[4*c+2];
      a3 = t[4*c+3];
      if (last)
        o[127-32*c -: 32] = {a0, a1, a2, a3};
      else
        o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o ^ rk;
  endfunction

endpackage

// File: rtl/aes128_ctr_stream_core.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly.
module aes128_encrypt
  import aes128_ctr_stream_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] plain_text,
  output logic [127:0] cipher_text,
  output logic         done,
  output logic         ready
);

  core_state_t  st_reg;
  logic [127:0] state_reg;
  logic [127:0] rk_reg;
  logic [7:0]   rcon_reg;
  logic [3:0]   round_reg;
  logic         done_reg;

  logic [127:0] rk_next;
  logic [127:0] state_next;

  assign rk_next    = key_step(rk_reg, rcon_reg);
  assign state_next = aes_round(state_reg, rk_next, round_reg == 4'(AES_ROUNDS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_reg    <= CORE_IDLE_S;
      state_reg <= '0;
      rk_reg    <= '0;
      rcon_reg  <= 8'h01;
      round_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      case (st_reg)
        CORE_IDLE_S: begin
          if (start) begin
            state_reg <= plain_text ^ key;
            rk_reg    <= key;
            rcon_reg  <= 8'h01;
            round_reg <= 4'd1;
            done_reg  <= 1'b0;
            st_reg    <= CORE_BUSY_S;
          end
        end
        default: begin
          state_reg <= state_next;
          rk_reg    <= rk_next;
          rcon_reg  <= xtime(rcon_reg);
          round_reg <= round_reg + 4'd1;
          if (round_reg == 4'(AES_ROUNDS)) begin
            done_reg <= 1'b1;
            st_reg   <= CORE_IDLE_S;
          end
        end
      endcase
    end
  end

  assign cipher_text = state_reg;
  assign done        = done_reg;
  assign ready       = (st_reg == CORE_IDLE_S);

endmodule

// File: rtl/aes128_ctr_stream.sv
// AES-128 CTR front end: collects a block of stream words, XORs it with the keystream
// produced by an external iterative core for {nonce,ctr}, then streams the result out.
module aes128_ctr_stream
  import aes128_ctr_stream_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter int NONCE_W = 96
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_valid_i,
  output logic                       cfg_ready_o,
  input  logic [AES_BLK_W-1:0]       key_i,
  input  logic [NONCE_W-1:0]         nonce_i,
  input  logic [AES_BLK_W-NONCE_W-1:0] ctr_i,
  input  logic [WORD_W-1:0]          s_data_i,
  input  logic                       s_valid_i,
  input  logic                       s_last_i,
  output logic                       s_ready_o,
  output logic [WORD_W-1:0]          m_data_o,
  output logic                       m_valid_o,
  output logic                       m_last_o,
  input  logic                       m_ready_i,
  output logic                       aes_start_o,
  output logic [AES_BLK_W-1:0]       aes_key_o,
  output logic [AES_BLK_W-1:0]       aes_block_o,
  input  logic                       aes_ready_i,
  input  logic                       aes_done_i,
  input  logic [AES_BLK_W-1:0]       aes_cipher_i,
  output logic                       ctr_wrap_o
);

  localparam int CTR_W = AES_BLK_W - NONCE_W;

  ctr_state_t           state_reg;
  logic [AES_BLK_W-1:0] key_reg;
  logic [AES_BLK_W-1:0] ks_reg;
  logic [NONCE_W-1:0]   nonce_reg;
  logic [CTR_W-1:0]     ctr_reg;
  logic [WORD_W-1:0]    data_reg [AES_WORDS];
  logic [2:0]           cnt_reg;
  logic [1:0]           idx_reg;
  logic                 last_reg;
  logic                 ks_vld_reg;
  logic                 data_done_reg;
  logic                 wrap_reg;
  logic                 cfg_ready_reg;
  logic                 s_ready_reg;
  logic                 m_valid_reg;
  logic                 m_last_reg;
  logic                 start_reg;

  logic [WORD_W-1:0]    out_word [AES_WORDS];

  // Word gi of the block occupies the gi-th 32-bit slice counted from the MSB.
  generate
    for (genvar gi = 0; gi < AES_WORDS; gi++) begin : g_word
      assign out_word[gi] = data_reg[gi] ^ ks_reg[AES_BLK_W-1-WORD_W*gi -: WORD_W];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE_S;
      key_reg       <= '0;
      ks_reg        <= '0;
      nonce_reg     <= '0;
      ctr_reg       <= '0;
      for (int i = 0; i < AES_WORDS; i++) data_reg[i] <= '0;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      last_reg      <= 1'b0;
      ks_vld_reg    <= 1'b0;
      data_done_reg <= 1'b0;
      wrap_reg      <= 1'b0;
      cfg_ready_reg <= 1'b1;
      s_ready_reg   <= 1'b0;
      m_valid_reg   <= 1'b0;
      m_last_reg    <= 1'b0;
      start_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE_S: begin
          if (cfg_valid_i) begin
            key_reg       <= key_i;
            nonce_reg     <= nonce_i;
            ctr_reg       <= ctr_i;
            wrap_reg      <= 1'b0;
            cfg_ready_reg <= 1'b0;
            state_reg     <= KICK_S;
          end
        end
        KICK_S: begin
          if (aes_ready_i) begin
            start_reg     <= 1'b1;
            ks_vld_reg    <= 1'b0;
            cnt_reg       <= '0;
            last_reg      <= 1'b0;
            data_done_reg <= 1'b0;
            s_ready_reg   <= 1'b1;
            state_reg     <= FILL_S;
          end
        end
        FILL_S: begin
          start_reg <= 1'b0;
          if (s_valid_i && s_ready_reg) begin
            data_reg[cnt_reg[1:0]] <= s_data_i;
            cnt_reg <= cnt_reg + 3'd1;
            if (cnt_reg == 3'd3 || s_last_i) begin
              s_ready_reg   <= 1'b0;
              data_done_reg <= 1'b1;
              last_reg      <= s_last_i;
            end
          end
          // While the start pulse is out, done still reflects the previous block.
          if (!start_reg && aes_done_i && !ks_vld_reg) begin
            ks_reg     <= aes_cipher_i;
            ks_vld_reg <= 1'b1;
          end
          if (data_done_reg && ks_vld_reg) begin
            idx_reg     <= '0;
            m_valid_reg <= 1'b1;
            m_last_reg  <= last_reg && (cnt_reg == 3'd1);
            state_reg   <= EMIT_S;
          end
        end
        default: begin
          if (m_valid_reg && m_ready_i) begin
            if ({1'b0, idx_reg} == cnt_reg - 3'd1) begin
              m_valid_reg <= 1'b0;
              m_last_reg  <= 1'b0;
              if (last_reg) begin
                cfg_ready_reg <= 1'b1;
                state_reg     <= IDLE_S;
              end else begin
                ctr_reg <= ctr_reg + CTR_W'(1);
                if (ctr_reg == '1) wrap_reg <= 1'b1;
                state_reg <= KICK_S;
              end
            end else begin
              idx_reg    <= idx_reg + 2'd1;
              m_last_reg <= last_reg && ({1'b0, idx_reg} + 3'd2 == cnt_reg);
            end
          end
        end
      endcase
    end
  end

  assign cfg_ready_o = cfg_ready_reg;
  assign s_ready_o   = s_ready_reg;
  assign m_valid_o   = m_valid_reg;
  assign m_last_o    = m_last_reg;
  assign m_data_o    = m_valid_reg ? out_word[idx_reg] : '0;
  assign aes_start_o = start_reg;
  assign aes_key_o   = key_reg;
  assign aes_block_o = {nonce_reg, ctr_reg};
  assign ctr_wrap_o  = wrap_reg;

endmodule

// File: tb/tb_aes128_ctr_stream.sv
// Directed bench for the CTR front end paired with the real iterative AES core,
// using the SP800-38A CTR-AES128 vectors.
module tb_aes128_ctr_stream;

  localparam logic [127:0] KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [95:0]  NONCE = 96'hf0f1f2f3f4f5f6f7f8f9fafb;

  localparam logic [31:0] PT [16] = '{
    32'h6bc1bee2, 32'h2e409f96, 32'he93d7e11, 32'h7393172a,
    32'hae2d8a57, 32'h1e03ac9c, 32'h9eb76fac, 32'h45af8e51,
    32'h30c81c46, 32'ha35ce411, 32'he5fbc119, 32'h1a0a52ef,
    32'hf69f2445, 32'hdf4f9b17, 32'had2b417b, 32'he66c3710};
  localparam logic [31:0] CT [16] = '{
    32'h874d6191, 32'hb620e326, 32'h1bef6864, 32'h990db6ce,
    32'h9806f66b, 32'h7970fdff, 32'h8617187b, 32'hb9fffdff,
    32'h5ae4df3e, 32'hdbd5d35e, 32'h5b4f0902, 32'h0db03eab,
    32'h1e031dda, 32'h2fbe03d1, 32'h792170a0, 32'hf3009cee};

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_valid_i, cfg_ready_o;
  logic [127:0] key_i;
  logic [95:0]  nonce_i;
  logic [31:0]  ctr_i;
  logic [31:0]  s_data_i, m_data_o;
  logic         s_valid_i, s_last_i, s_ready_o;
  logic         m_valid_o, m_last_o, m_ready_i;
  logic         aes_start_o, aes_ready_i, aes_done_i, ctr_wrap_o;
  logic [127:0] aes_key_o, aes_block_o, aes_cipher_i;
  logic         aes_rst_n;

  int n_vec = 0;
  int n_err = 0;
  logic [127:0] blk_q [$];

  always #5 clk = ~clk;
  assign aes_rst_n = ~rst;

  aes128_ctr_stream dut (
    .clk(clk), .rst(rst),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .key_i(key_i), .nonce_i(nonce_i), .ctr_i(ctr_i),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_last_i(s_last_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o), .m_ready_i(m_ready_i),
    .aes_start_o(aes_start_o), .aes_key_o(aes_key_o), .aes_block_o(aes_block_o),
    .aes_ready_i(aes_ready_i), .aes_done_i(aes_done_i), .aes_cipher_i(aes_cipher_i),
    .ctr_wrap_o(ctr_wrap_o)
  );

  aes128_encrypt core (
    .clk(clk), .rst_n(aes_rst_n), .start(aes_start_o), .key(aes_key_o),
    .plain_text(aes_block_o), .cipher_text(aes_cipher_i), .done(aes_done_i),
    .ready(aes_ready_i)
  );

  // Record the counter block handed to the core on every start pulse.
  always @(negedge clk) if (aes_start_o) blk_q.push_back(aes_block_o);

  task automatic check_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_rst(input string tag);
    check_vec({tag, "_cfg_ready"}, cfg_ready_o, 1);
    check_vec({tag, "_s_ready"},   s_ready_o, 0);
    check_vec({tag, "_m_valid"},   m_valid_o, 0);
    check_vec({tag, "_m_last"},    m_last_o, 0);
    check_vec({tag, "_m_data"},    m_data_o, 0);
    check_vec({tag, "_start"},     aes_start_o, 0);
    check_vec({tag, "_wrap"},      ctr_wrap_o, 0);
    check_vec({tag, "_block"},     aes_block_o, 0);
    check_vec({tag, "_key"},       aes_key_o, 0);
  endtask

  task automatic do_cfg(input logic [31:0] ctr);
    int g = 0;
    @(negedge clk);
    while (!cfg_ready_o && g < 500) begin
      @(negedge clk);
      g++;
    end
    check_vec("cfg_ready_wait", cfg_ready_o, 1);
    cfg_valid_i = 1'b1;
    key_i       = KEY;
    nonce_i     = NONCE;
    ctr_i       = ctr;
    @(negedge clk);
    cfg_valid_i = 1'b0;
    $display("cfg ctr=%h", ctr);
  endtask

  task automatic send_words(input int n, input bit last, input int gap, input bit zero);
    int i = 0;
    int g = 0;
    while (i < n && g < 5000) begin
      @(negedge clk);
      g++;
      s_valid_i = ($urandom_range(0, 99) >= gap);
      s_data_i  = zero ? 32'h0 : PT[i];
      s_last_i  = last && (i == n - 1);
      if (s_valid_i && s_ready_o) i++;
    end
    if (i != n) check_vec("send_timeout", i, n);
    @(negedge clk);
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  task automatic collect(input int n, input bit last, input int stall, input bit chk);
    int got = 0;
    int g = 0;
    while (got < n && g < 5000) begin
      @(negedge clk);
      g++;
      m_ready_i = ($urandom_range(0, 99) >= stall);
      if (m_valid_o && m_ready_i) begin
        $display("out %0d: data=%h last=%0b", got, m_data_o, m_last_o);
        if (chk) check_vec($sformatf("data_%0d", got), m_data_o, CT[got]);
        check_vec($sformatf("last_%0d", got), m_last_o, last && (got == n - 1));
        got++;
      end
    end
    if (got != n) check_vec("collect_timeout", got, n);
    m_ready_i = 1'b1;
  endtask

  initial begin
    int extra;
    int g;
    rst = 1'b1;
    cfg_valid_i = 0; key_i = '0; nonce_i = '0; ctr_i = '0;
    s_data_i = '0; s_valid_i = 0; s_last_i = 0; m_ready_i = 1;
    repeat (3) @(negedge clk);
    check_rst("reset");
    rst = 1'b0;

    // Two full blocks of one message, counter fcfdfeff -> fcfdff00.
    blk_q.delete();
    do_cfg(32'hfcfdfeff);
    fork
      send_words(8, 1, 0, 0);
      collect(8, 1, 0, 1);
    join
    @(negedge clk);
    check_vec("t12_idle", cfg_ready_o, 1);
    check_vec("t12_starts", blk_q.size(), 2);
    if (blk_q.size() == 2) begin
      check_vec("t1_block", blk_q[0], {NONCE, 32'hfcfdfeff});
      check_vec("t2_ctr_lo", blk_q[1][31:0], 32'hfcfdff00);
    end
    check_vec("t12_nowrap", ctr_wrap_o, 0);

    // Counter wrap.
    blk_q.delete();
    do_cfg(32'hffffffff);
    fork
      send_words(8, 1, 0, 1);
      collect(8, 1, 0, 0);
    join
    @(negedge clk);
    check_vec("t4_starts", blk_q.size(), 2);
    if (blk_q.size() == 2) begin
      check_vec("t4_block0", blk_q[0], {NONCE, 32'hffffffff});
      check_vec("t4_block1", blk_q[1], {NONCE, 32'h00000000});
    end
    check_vec("t4_wrap_set", ctr_wrap_o, 1);
    do_cfg(32'hfcfdfeff);
    check_vec("t4_wrap_clr", ctr_wrap_o, 0);

    // Partial block of two words.
    fork
      send_words(2, 1, 0, 0);
      collect(2, 1, 0, 1);
    join
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (m_valid_o) extra++;
    end
    check_vec("t3_no_extra", extra, 0);
    check_vec("t3_idle", cfg_ready_o, 1);

    // Four blocks with source gaps and sink backpressure.
    do_cfg(32'hfcfdfeff);
    fork
      send_words(16, 1, 40, 0);
      collect(16, 1, 40, 1);
    join

    // Reset while collecting input.
    do_cfg(32'hfcfdfeff);
    send_words(2, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_rst("t6_fill");
    rst = 1'b0;

    // Reset while output is stalled.
    do_cfg(32'hfcfdfeff);
    m_ready_i = 1'b0;
    send_words(4, 0, 0, 0);
    g = 0;
    while (!m_valid_o && g < 200) begin
      @(negedge clk);
      g++;
    end
    check_vec("t6_emit_reached", m_valid_o, 1);
    check_vec("t6_emit_word0", m_data_o, CT[0]);
    rst = 1'b1;
    @(negedge clk);
    check_rst("t6_emit");
    rst = 1'b0;

    do_cfg(32'hfcfdfeff);
    fork
      send_words(4, 1, 0, 0);
      collect(4, 1, 0, 1);
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
